ram_512: RTL and testbench
==========================

// Module: ram_512
// PURPOSE
//   512-word x 16-bit random-access memory: one clocked write port, one asynchronous read port.
//   Memory tier of the hack-style hierarchy (RAM8 -> RAM64 -> RAM512 -> RAM4K).
//   Organised as 8 banks of 64 words:
//     - addr[8:6] selects the bank.
//     - addr[5:0] selects the word within the bank.
// PARAMETERS
//   WIDTH   16   data word width in bits
//   DEPTH   512  number of words; fixed as 8 banks x 64 words
//   AW      9    address width, log2(DEPTH)
// PORTS
//   clk    in   1      single clock; all state changes on its rising edge
//   rst    in   1      synchronous, active-high reset
//   out    out  16     read data, the word at addr
//   in     in   16     write data
//   addr   in   9      word address; shared by read and write
//   load   in   1      write enable, sampled at the rising clk edge
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - Reset: rst=1 at a rising clk edge clears all 512 words to 16'd0.
//     - out then reads 0 for every address.
//     - rst has priority over load; no write occurs in that cycle.
//     - Between edges, rst has no effect.
//   - Write: rst=0 and load=1 at a rising clk edge.
//     - mem[addr] <= in.
//     - Exactly one word changes; all other words, including other banks, keep their value.
//   - Hold: rst=0 and load=0 at the edge leaves the memory unchanged.
//   - Read: out = mem[addr], combinational.
//     - Zero-cycle latency: a change on addr updates out within the same delta/cycle, no clk edge needed.
//     - Reading never modifies the memory.
//   - Read-during-write, same address:
//     - Before the edge, out shows the old word.
//     - Immediately after the edge, out shows the newly written word (write-through after edge).
//   - Address decode:
//     - All 9 bits are significant; no aliasing between addresses.
//     - 0 and 511 are valid, with no wrap-around beyond 9 bits.
//   - load or in changing while clk is stable has no effect on stored data.
//   - Power-up contents before the first reset: undefined (X allowed); the bench resets first.
// TESTING
//   1. Reset, then sweep addr 0..511 with load=0 -> out == 0 at every address.
//   2. Write with load=1, one clk pulse each:
//      - 2@0, 3@1, 4@2, 5@0x013, 6@0x00C, 7@0x055, 8@0x006, 9@0x1A7.
//      - Then load=0, read each address -> 2,3,4,5,6,7,8,9 respectively.
//   3. Bank isolation:
//      - Write 16'hAAAA@0x03F and 16'h5555@0x040 (adjacent banks).
//      - Read back -> AAAA and 5555; address 0x07F still 0.
//   4. Hold: load=0, in=16'hFFFF, clk pulse at addr 0 -> out stays 2.
//      Boundary: write 16'h1234@511 -> out 1234 at 511; address 0 unaffected.
//   5. Read-during-write: addr=1 holds 3; set in=16'd77, load=1.
//      - out == 3 before the edge.
//      - out == 77 after the edge.
//   6. Reset priority: rst=1 and load=1 with in=16'd50 at addr 0x1A7 -> after the edge, out == 0 at 0x1A7 and at all other addresses.

Source files
------------

// File: rtl/ram_512.sv
// 512 x 16 memory built from eight 64-word banks: clocked write, combinational read.
// A reset clears every word, so the storage is register-based rather than block RAM.
module ram_512 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    addr,
    input  logic             load
);
    localparam int BANKS      = 8;
    localparam int BW         = $clog2(BANKS);
    localparam int BANK_DEPTH = DEPTH / BANKS;
    localparam int WW         = AW - BW;

    logic [BW-1:0]    bank_sel;
    logic [WW-1:0]    word_sel;
    logic [WIDTH-1:0] bank_out [BANKS];

    // Upper address bits pick the bank, lower bits pick the word inside it.
    assign bank_sel = addr[AW-1:WW];
    assign word_sel = addr[WW-1:0];

    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
            logic             bank_we;
            logic [WIDTH-1:0] mem_reg [BANK_DEPTH];

            assign bank_we = load && (bank_sel == BW'(gi));

            // Reset wins over load: a reset edge never performs a write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < BANK_DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else if (bank_we) begin
                    mem_reg[word_sel] <= in;
                end
            end

            assign bank_out[gi] = mem_reg[word_sel];
        end
    endgenerate

    assign out = bank_out[bank_sel];

endmodule

// File: tb/tb_ram_512.sv
// Directed and randomized checks of ram_512 against a flat 512-entry array model.
module tb_ram_512;
    logic        clk;
    logic        rst;
    logic [15:0] out;
    logic [15:0] in;
    logic [8:0]  addr;
    logic        load;

    int errors = 0;
    int checks = 0;
    logic [15:0] model [512];

    ram_512 dut (
        .clk  (clk),
        .rst  (rst),
        .out  (out),
        .in   (in),
        .addr (addr),
        .load (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s addr=%0h observed=%h expected=%h", tag, addr, out, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [8:0] a, input logic [15:0] exp);
        @(negedge clk);
        addr = a;
        #1;
        $display("read  %-10s addr=%03h out=%h exp=%h", tag, a, out, exp);
        check(tag, exp);
    endtask

    task automatic write_word(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a;
        in   = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        model[a] = d;
        $display("write addr=%03h data=%h", a, d);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            addr = 9'(a);
            #1;
            check(tag, model[a]);
        end
        $display("sweep %-10s done", tag);
    endtask

    initial begin
        logic [8:0]  wa [8];
        logic [15:0] wd [8];
        logic [8:0]  ra;
        logic [15:0] rd;

        wa = '{9'h000, 9'h001, 9'h002, 9'h013, 9'h00C, 9'h055, 9'h006, 9'h1A7};
        wd = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};

        rst  = 1'b1;
        load = 1'b0;
        in   = '0;
        addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 512; i++) model[i] = 16'd0;

        // 1: everything reads zero after reset
        sweep("reset");

        // 2: directed writes and readback
        for (int i = 0; i < 8; i++) write_word(wa[i], wd[i]);
        for (int i = 0; i < 8; i++) read_check("wr_rd", wa[i], wd[i]);

        // 3: adjacent-bank isolation
        write_word(9'h03F, 16'hAAAA);
        write_word(9'h040, 16'h5555);
        read_check("bank_lo", 9'h03F, 16'hAAAA);
        read_check("bank_hi", 9'h040, 16'h5555);
        read_check("bank_oth", 9'h07F, 16'h0000);

        // 4: hold with load low, then top-address boundary
        @(negedge clk);
        addr = 9'h000;
        in   = 16'hFFFF;
        load = 1'b0;
        @(posedge clk);
        #1;
        check("hold", 16'd2);
        write_word(9'h1FF, 16'h1234);
        read_check("top", 9'h1FF, 16'h1234);
        read_check("top_zero", 9'h000, 16'd2);

        // load pulse between edges must not write
        @(negedge clk);
        addr = 9'h010;
        in   = 16'hBEEF;
        load = 1'b1;
        #2;
        load = 1'b0;
        @(posedge clk);
        #1;
        check("glitch", model[9'h010]);

        // 5: read-during-write at the same address
        @(negedge clk);
        addr = 9'h001;
        in   = 16'd77;
        load = 1'b1;
        #1;
        check("rdw_old", 16'd3);
        @(posedge clk);
        #1;
        load = 1'b0;
        model[1] = 16'd77;
        check("rdw_new", 16'd77);

        // randomized writes/reads against the model
        for (int n = 0; n < 400; n++) begin
            ra = 9'($urandom_range(511));
            if ($urandom_range(1) == 1) begin
                rd = 16'($urandom);
                write_word(ra, rd);
            end
            ra = 9'($urandom_range(511));
            read_check("random", ra, model[ra]);
        end
        sweep("post_rand");

        // 6: reset has priority over load
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        in   = 16'd50;
        addr = 9'h1A7;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 512; i++) model[i] = 16'd0;
        check("rst_prio", 16'd0);
        sweep("rst_all");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
